reg_bank_decoded: RTL

Parametrised register bank built around a generalised ADDR_W-to-2^ADDR_W write decoder, replacing the fixed 4-to-16 decode stage.
- One write port and NREAD combinational read ports.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Registered one-hot write-strobe monitor and sticky per-register dirty bits, for pipeline hazard tracking in the 32-bit datapath.

---
 rtl/reg_bank_decoded.sv | 59 +++++
 1 files changed

// File: rtl/reg_bank_decoded.sv
// reg_bank_decoded: parametrised register bank with generalised write decoder, bypass reads and hazard-tracking status
module reg_bank_decoded #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 4,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*WIDTH-1:0]   rd_data,
  input  logic                     clr_dirty,
  output logic [2**ADDR_W-1:0]     wr_onehot,
  output logic [2**ADDR_W-1:0]     dirty,
  output logic [15:0]              wr_count
);
  localparam int DEPTH = 2**ADDR_W;
  // bit 0 of the decode is masked off when register 0 is hardwired to zero
  localparam logic [DEPTH-1:0] WE_MASK = {{(DEPTH-1){1'b1}}, 1'(ZERO_R0 == 0)};
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] we_vec;
  logic [DEPTH-1:0] wr_onehot_q, wr_onehot_d;
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [15:0]      wr_count_q, wr_count_d;
  always_comb begin
    we_vec = (wr_en ? (DEPTH'(1) << wr_addr) : '0) & WE_MASK;
    for (int i = 0; i < DEPTH; i++) regs_d[i] = we_vec[i] ? wr_data : regs_q[i];
    wr_onehot_d = we_vec;
    dirty_d     = (clr_dirty ? '0 : dirty_q) | we_vec;
    wr_count_d  = wr_count_q + 16'(|we_vec);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_onehot_q <= '0;
      dirty_q     <= '0;
      wr_count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      wr_onehot_q <= wr_onehot_d;
      dirty_q     <= dirty_d;
      wr_count_q  <= wr_count_d;
    end
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*WIDTH +: WIDTH] = (ZERO_R0 != 0 && a == '0) ? '0 :
                                       (BYPASS != 0 && we_vec[a]) ? wr_data : regs_q[a];
  end
  assign wr_onehot = wr_onehot_q;
  assign dirty     = dirty_q;
  assign wr_count  = wr_count_q;
endmodule
